// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding memory request at a time, IDLE -> BUSY -> DONE.
// Define LSU_TIMEOUT_EN to abort requests left unacknowledged for TIMEOUT_CYCLES BUSY cycles.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        load,
  input  logic        store,
  input  logic [15:0] addr,
  input  logic [15:0] store_data,
  input  logic [2:0]  dest_reg,
  output logic        stall,
  output logic        wb_valid,
  output logic [2:0]  wb_reg,
  output logic [15:0] wb_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        misalign_err,
  output logic        timeout_err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state, next_state;
  logic       access, launch, misalign, expire;
  logic [2:0] cap_dest;

  assign access   = (state == IDLE) && clk_en && (load || store);
  assign launch   = access && !addr[0];
  assign misalign = access && addr[0];

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  // expire fires in the last allowed BUSY cycle that still sees no ack
  assign expire = (state == BUSY) && !mem_ack && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (launch)
        tmo_cnt <= '0;
      else if (state == BUSY && !mem_ack)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (expire)
        timeout_err <= 1'b1;
    end
  end
`else
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (launch) next_state = BUSY;
      BUSY:    if (mem_ack || expire) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // launch term gated by reset so every output reads 0 while reset is held
  always_comb begin
    stall = (launch && !reset) || (state == BUSY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      cap_dest     <= '0;
      wb_valid     <= 1'b0;
      wb_reg       <= '0;
      wb_data      <= '0;
      misalign_err <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (launch) begin
        mem_req   <= 1'b1;
        mem_we    <= store;
        mem_addr  <= addr;
        mem_wdata <= store_data;
        cap_dest  <= dest_reg;
      end else if (state == BUSY && (mem_ack || expire)) begin
        mem_req <= 1'b0;
        if (mem_ack && !mem_we) begin
          wb_valid <= 1'b1;
          wb_reg   <= cap_dest;
          wb_data  <= mem_rdata;
        end
      end
      if (misalign)
        misalign_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level model checked every cycle plus directed literal checks.
module tb_load_store_unit;
  localparam int TO = 4;
`ifdef LSU_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, clk_en, load, store, mem_ack;
  logic [15:0] addr, store_data, mem_rdata;
  logic [2:0]  dest_reg;
  logic        stall, wb_valid, mem_req, mem_we, misalign_err, timeout_err;
  logic [2:0]  wb_reg;
  logic [15:0] wb_data, mem_addr, mem_wdata;

  int checks = 0;
  int failures = 0;
  int stall_n = 0, req_n = 0, reqc_n = 0, wbv_n = 0;
  int b_stall, b_req, b_reqc, b_wbv;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .load(load), .store(store),
    .addr(addr), .store_data(store_data), .dest_reg(dest_reg),
    .stall(stall), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: one in-flight transaction record plus a one-cycle completion slot.
  logic        m_inflight, m_finishing, m_we, m_wbv, m_mis, m_to;
  logic [15:0] m_addr, m_wdata, m_wbdata;
  logic [2:0]  m_dest, m_wbreg;
  int          m_waited;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_inflight <= 0; m_finishing <= 0; m_we <= 0; m_wbv <= 0; m_mis <= 0; m_to <= 0;
      m_addr <= 0; m_wdata <= 0; m_wbdata <= 0; m_dest <= 0; m_wbreg <= 0; m_waited <= 0;
    end else begin
      m_wbv <= 0;
      m_finishing <= 0;
      if (m_inflight) begin
        if (mem_ack) begin
          m_inflight <= 0; m_finishing <= 1;
          if (!m_we) begin m_wbv <= 1; m_wbdata <= mem_rdata; m_wbreg <= m_dest; end
        end else if (TIMEOUT_ON && m_waited + 1 >= TO) begin
          m_inflight <= 0; m_finishing <= 1; m_to <= 1;
        end else m_waited <= m_waited + 1;
      end else if (!m_finishing && clk_en && (load || store)) begin
        if (addr[0]) m_mis <= 1;
        else begin
          m_inflight <= 1; m_we <= store; m_addr <= addr; m_wdata <= store_data;
          m_dest <= dest_reg; m_waited <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    static logic prev_req = 1'b0;
    if (!reset) begin
      chk("stall", stall, m_inflight ||
          (!m_finishing && clk_en && (load || store) && !addr[0]));
      chk("mem_req", mem_req, m_inflight);
      if (m_inflight) begin
        chk("mem_we", mem_we, m_we);
        chk("mem_addr", mem_addr, m_addr);
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      chk("wb_valid", wb_valid, m_wbv);
      chk("wb_reg", wb_reg, m_wbreg);
      chk("wb_data", wb_data, m_wbdata);
      chk("misalign_err", misalign_err, m_mis);
      chk("timeout_err", timeout_err, m_to);
      if (stall) stall_n++;
      if (mem_req) reqc_n++;
      if (mem_req && !prev_req) req_n++;
      if (wb_valid) wbv_n++;
      prev_req = mem_req;
    end else prev_req = 1'b0;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark();
    b_stall = stall_n; b_req = req_n; b_reqc = reqc_n; b_wbv = wbv_n;
  endtask

  initial begin
    reset = 1; clk_en = 0; load = 0; store = 0; mem_ack = 0;
    addr = 0; store_data = 0; mem_rdata = 0; dest_reg = 0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_errs", {misalign_err, timeout_err}, 0);
    step(2);
    reset = 0; clk_en = 1;
    step(1);

    // aligned load, ack in first request cycle
    mark();
    load = 1; addr = 16'h0010; dest_reg = 3'd3;
    step(1);
    mem_ack = 1; mem_rdata = 16'hBEEF;
    step(1);
    mem_ack = 0;
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_reg", wb_reg, 3);
    chk("ld_wb_data", wb_data, 16'hBEEF);
    load = 0;
    step(2);
    chk("ld_stall_cycles", stall_n - b_stall, 2);
    chk("ld_wb_cycles", wbv_n - b_wbv, 1);
    chk("ld_requests", req_n - b_req, 1);

    // store acked on its fifth request cycle, clk_en dropped mid-flight
    mark();
    store = 1; addr = 16'h0020; store_data = 16'h1234;
    step(1);
    clk_en = 0;
    chk("st_mem_we", mem_we, 1);
    chk("st_mem_wdata", mem_wdata, 16'h1234);
    step(4);
    mem_ack = 1; mem_rdata = 16'hDEAD;
    step(1);
    mem_ack = 0; store = 0; clk_en = 1;
    step(2);
    chk("st_stall_cycles", stall_n - b_stall, 6);
    chk("st_req_cycles", reqc_n - b_reqc, 5);
    chk("st_wb_cycles", wbv_n - b_wbv, 0);

    // misaligned load
    mark();
    load = 1; addr = 16'h0011; dest_reg = 3'd6;
    step(1);
    load = 0;
    chk("mis_err", misalign_err, 1);
    step(3);
    chk("mis_stall_cycles", stall_n - b_stall, 0);
    chk("mis_requests", req_n - b_req, 0);
    chk("mis_sticky", misalign_err, 1);

    // reset two cycles into BUSY, then a stray ack
    load = 1; addr = 16'h0040; dest_reg = 3'd5;
    step(2);
    chk("pre_rst_req", mem_req, 1);
    reset = 1; load = 0;
    #1;
    chk("rst_req_drop", mem_req, 0);
    chk("rst_stall_drop", stall, 0);
    chk("rst_mis_clear", misalign_err, 0);
    step(1);
    reset = 0; mem_ack = 1; mem_rdata = 16'h5555;
    step(1);
    mem_ack = 0;
    chk("stray_ack_wb", wb_valid, 0);
    chk("stray_ack_req", mem_req, 0);
    step(1);

    // back-to-back loads held through DONE
    mark();
    load = 1; addr = 16'h0100; dest_reg = 3'd1;
    step(1);
    mem_ack = 1; mem_rdata = 16'h1111;
    step(1);
    mem_ack = 0;
    chk("b2b_wb1", wb_data, 16'h1111);
    step(1);
    addr = 16'h0102; dest_reg = 3'd2;
    step(1);
    mem_ack = 1; mem_rdata = 16'h2222;
    step(1);
    mem_ack = 0;
    chk("b2b_wb2", wb_data, 16'h2222);
    chk("b2b_wbreg2", wb_reg, 2);
    load = 0;
    step(2);
    chk("b2b_requests", req_n - b_req, 2);
    chk("b2b_wb_cycles", wbv_n - b_wbv, 2);

    // unacknowledged request
    mark();
    load = 1; addr = 16'h0200; dest_reg = 3'd4;
    step(1);
`ifdef LSU_TIMEOUT_EN
    step(4);
    chk("to_req_drop", mem_req, 0);
    chk("to_err", timeout_err, 1);
    chk("to_wb_valid", wb_valid, 0);
    chk("to_stall", stall, 0);
    load = 0;
    step(2);
    chk("to_req_cycles", reqc_n - b_reqc, TO);
    chk("to_sticky", timeout_err, 1);
`else
    step(10);
    chk("noto_req_held", mem_req, 1);
    chk("noto_stall", stall, 1);
    chk("noto_err", timeout_err, 0);
    mem_ack = 1; mem_rdata = 16'h4242;
    step(1);
    mem_ack = 0; load = 0;
    chk("noto_wb", wb_data, 16'h4242);
    step(2);
    chk("noto_req_cycles", reqc_n - b_reqc, 11);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, BUSY cycles without mem_ack before abort; used only with LSU_TIMEOUT_EN.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 clk_en  in  1  processor run enable; low blocks new launches only.
REQ-005 load  in  1  decoded LOAD of current instruction.
REQ-006 store  in  1  decoded STOR of current instruction.
REQ-007 addr  in  16  byte address (ALU reg1+imm result).
REQ-008 store_data  in  16  store source (register indexed by destination field).
REQ-009 dest_reg  in  3  load destination register number.
REQ-010 stall  out  1  high = hold PC/regfile (gates processor clk_en).
REQ-011 wb_valid  out  1  one-cycle load writeback strobe.
REQ-012 wb_reg  out  3  load writeback register number.
REQ-013 wb_data  out  16  load writeback data.
REQ-014 mem_req  out  1  memory request, registered.
REQ-015 mem_we  out  1  1 = write, 0 = read; valid while mem_req.
REQ-016 mem_addr  out  16  memory byte address; valid while mem_req.
REQ-017 mem_wdata  out  16  write data; valid while mem_req and mem_we.
REQ-018 mem_ack  in  1  memory completion, one cycle per request.
REQ-019 mem_rdata  in  16  read data, valid with mem_ack on reads.
REQ-020 misalign_err  out  1  sticky: misaligned access attempted.
REQ-021 timeout_err  out  1  sticky: request timed out.

Function
REQ-022 FSM states IDLE, BUSY, DONE; IDLE after reset.
REQ-023 Launch: IDLE, clk_en=1, (load|store)=1, addr[0]=0 -> capture addr, store_data, dest_reg, mem_we=store; enter BUSY with mem_req=1 next cycle.
REQ-024 load and store both high: treated as store.
REQ-025 stall = launch condition of REQ-023 (combinational) OR state==BUSY; low in IDLE otherwise and in DONE.
REQ-026 BUSY: mem_req, mem_we, mem_addr, mem_wdata held stable until the cycle mem_ack=1.
REQ-027 BUSY with mem_ack=1: next cycle DONE, mem_req=0; on read, wb_data=mem_rdata, wb_reg=captured dest_reg, wb_valid=1 for DONE cycle only.
REQ-028 mem_ack in first BUSY cycle accepted; minimum: launch cycle T, req T+1, DONE/wb_valid T+2, stall high for T and T+1 only.
REQ-029 DONE -> IDLE unconditionally; load/store inputs ignored in DONE (same instruction, no relaunch).
REQ-030 mem_ack outside BUSY ignored; no state change.
REQ-031 Misaligned (addr[0]=1) in IDLE with clk_en and load|store: no memory access, no stall, no writeback, misalign_err set next cycle.
REQ-032 clk_en=0 does not freeze BUSY or DONE; in-flight transaction completes.
REQ-033 wb_valid, mem_req low in IDLE; wb_data/wb_reg hold last value.

Reset
REQ-034 reset high: state IDLE, all outputs 0, errors and timeout counter cleared, immediately (async).
REQ-035 Reset mid-BUSY: mem_req drops at once, no writeback; later mem_ack ignored.

Configuration
REQ-036 Macro LSU_TIMEOUT_EN defined: counter clears on BUSY entry, increments each BUSY cycle without ack; at TIMEOUT_CYCLES without ack -> mem_req=0, timeout_err=1 (sticky), enter DONE with wb_valid=0.
REQ-037 LSU_TIMEOUT_EN undefined: BUSY waits indefinitely; timeout_err constant 0; no counter logic.

Verification
REQ-038 LOAD addr=16'h0010, mem_ack on first req cycle, mem_rdata=16'hBEEF, dest_reg=3 -> stall 2 cycles, wb_valid one cycle, wb_reg=3, wb_data=16'hBEEF.
REQ-039 STOR addr=16'h0020, store_data=16'h1234, ack after 5 cycles -> mem_we=1, addr/wdata stable 5 cycles, stall 6 cycles, wb_valid never high.
REQ-040 LOAD addr=16'h0011 -> no mem_req, stall 0, misalign_err=1 until reset.
REQ-041 Reset asserted 2 cycles into BUSY -> mem_req=0 same cycle, state IDLE, later stray mem_ack ignored.
REQ-042 With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_req drops after 4 BUSY cycles, timeout_err=1, wb_valid=0, stall released.
REQ-043 Back-to-back LOADs held on inputs through DONE -> exactly one request per instruction, no relaunch in DONE.
